counter_sequencer: RTL
======================

Name: counter_sequencer

Overview:
Run controller for the 4-bit enable counter datapath. It clears the counter, gates its enable until a programmed terminal value is reached, and optionally reloads for a programmed number of periods. It signals wrap and completion. It sits beside the counter in the board top level; software-style config and start/stop come from the board control logic.

Parameters:
WIDTH, 4, counter width; must match the counter datapath.
REPEAT_WIDTH, 4, width of the repeat-count field.

Ports:
clock_i  in  1  system clock, rising edge.
reset_i  in  1  synchronous, active-high reset.
cfg_we_i  in  1  config write strobe; honoured only in IDLE.
cfg_limit_i  in  WIDTH  terminal count value L.
cfg_periodic_i  in  1  1 = auto-reload mode, 0 = one-shot.
cfg_repeat_i  in  REPEAT_WIDTH  extra periods R in periodic mode; 0 = run forever.
start_i  in  1  begin a run; ignored unless IDLE.
stop_i  in  1  abort the run; priority over start_i and all other events.
pause_i  in  1  level; holds the counter while high.
counter_value_i  in  WIDTH  current counter datapath output.
count_enable_o  out  1  drives the counter enable.
counter_clear_o  out  1  one-cycle clear pulse to the counter.
busy_o  out  1  high in every state except IDLE.
wrap_o  out  1  one-cycle pulse on each periodic reload.
done_o  out  1  one-cycle pulse on normal completion.
repeat_left_o  out  REPEAT_WIDTH  remaining reloads.

Behaviour:
- Reset: state IDLE. All outputs 0. Config registers are L=0, periodic=0, R=0. Shadow registers are 0.
- Config registers load on cfg_we_i in IDLE only. cfg_we_i while busy is dropped.
- start_i in IDLE copies config into shadow registers, including repeat_left = R. A config write in the same cycle as start_i: start copies the old values.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: start_i goes to CLEAR.
- CLEAR: counter_clear_o=1 and count_enable_o=0 for exactly one cycle, then RUN.
- RUN: count_enable_o = !pause_i && (counter_value_i != L_shadow). This is combinational, so the counter halts exactly at L.
- RUN exit when counter_value_i == L_shadow:
  - one-shot: go to DONE.
  - periodic with R_shadow==0: go to CLEAR, pulse wrap_o, run forever.
  - periodic with repeat_left>0: decrement repeat_left, go to CLEAR, pulse wrap_o.
  - periodic with repeat_left==0 and R_shadow!=0: go to DONE.
- wrap_o is high during the reload CLEAR cycle only.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing, start sampled at edge 0: CLEAR in cycle 1, RUN from cycle 2. count_enable_o is high for L cycles when unpaused. done_o is in cycle 3+L; busy_o covers cycles 1..3+L. Each periodic period takes L+2 cycles.
- L=0: the value reads 0 after clear, so RUN exits on its first cycle with no enable.
- pause_i extends RUN cycle-for-cycle with no other effect. pause_i is ignored outside RUN.
- stop_i in a non-IDLE state: next state IDLE. No done_o or wrap_o. count_enable_o is forced 0 in the same cycle. The counter keeps its value.
- reset_i mid-run: same as the reset values above, takes precedence over stop_i.
- The counter wraps 2^WIDTH-1 to 0 naturally. Because of the combinational gating it never passes L while in RUN.

Decomposition:
- counter_sequencer_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, DONE);
  - the default WIDTH and REPEAT_WIDTH constants;
  - a config struct {limit, periodic, repeat}.
- No sub-module. The bench instantiates the existing counter datapath; clear is mapped onto the counter's reset, inverted.

Test Plan:
- One-shot, L=5, start at cycle 0 -> clear in cycle 1; enable high cycles 2-6; counter reaches 5 in cycle 7; done_o in cycle 8; busy_o high cycles 1-8; final counter 5.
- Periodic, L=3, R=2 -> three periods of 5 cycles; wrap_o twice; done_o once; repeat_left_o steps 2,1,0; counter ends at 3.
- L=0 one-shot -> enable never asserted; done_o in cycle 3.
- L=4, pause_i high for 3 cycles mid-RUN -> done_o delayed by exactly 3 cycles, to cycle 10.
- stop_i at counter=2 (L=9) -> IDLE next cycle; no done_o; counter holds 2; a following start_i clears the counter to 0 and reruns.
- cfg_we_i with L=7 while busy, then a new start -> the second run still uses the old L; periodic R=0 gives continuous wraps until stop_i.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared types and defaults for the counter run controller.
package counter_sequencer_pkg;

   localparam int unsigned DEF_WIDTH        = 4;
   localparam int unsigned DEF_REPEAT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0]        limit;
      logic                        periodic;
      logic [DEF_REPEAT_WIDTH-1:0] repeat_cnt;
   } cfg_t;

endpackage

// File: rtl/counter_sequencer.sv
// Run controller for the enable counter: clear, gate enable up to a terminal
// value, optionally reload for a programmed number of periods.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH        = DEF_WIDTH,
   parameter int unsigned REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    cfg_we_i,
   input  logic [WIDTH-1:0]        cfg_limit_i,
   input  logic                    cfg_periodic_i,
   input  logic [REPEAT_WIDTH-1:0] cfg_repeat_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic                    pause_i,
   input  logic [WIDTH-1:0]        counter_value_i,
   output logic                    count_enable_o,
   output logic                    counter_clear_o,
   output logic                    busy_o,
   output logic                    wrap_o,
   output logic                    done_o,
   output logic [REPEAT_WIDTH-1:0] repeat_left_o
);

   typedef struct packed {
      logic [WIDTH-1:0]        limit;
      logic                    periodic;
      logic [REPEAT_WIDTH-1:0] repeat_cnt;
   } run_cfg_t;

   state_t                  r_state;
   state_t                  w_next;
   run_cfg_t                r_cfg;
   run_cfg_t                r_shadow;
   logic [REPEAT_WIDTH-1:0] r_repeat_left;
   logic                    r_wrap;
   logic                    w_at_limit;
   logic                    w_load;
   logic                    w_reload;

   assign w_at_limit    = (counter_value_i == r_shadow.limit);
   assign busy_o        = (r_state != ST_IDLE);
   assign repeat_left_o = r_repeat_left;

   always_comb begin
      w_next          = r_state;
      w_load          = 1'b0;
      w_reload        = 1'b0;
      count_enable_o  = 1'b0;
      counter_clear_o = 1'b0;
      done_o          = 1'b0;
      wrap_o          = r_wrap;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_next = ST_CLEAR;
               w_load = 1'b1;
            end
         end
         ST_CLEAR: begin
            counter_clear_o = 1'b1;
            w_next          = ST_RUN;
         end
         ST_RUN: begin
            count_enable_o = !pause_i && !w_at_limit;
            // A paused cycle holds RUN completely, including the exit decision.
            if (!pause_i && w_at_limit) begin
               if (r_shadow.periodic &&
                   (r_shadow.repeat_cnt == '0 || r_repeat_left != '0)) begin
                  w_next   = ST_CLEAR;
                  w_reload = 1'b1;
               end else begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort overrides every event and leaves the counter untouched.
      if (stop_i) begin
         w_next          = ST_IDLE;
         w_load          = 1'b0;
         w_reload        = 1'b0;
         count_enable_o  = 1'b0;
         counter_clear_o = 1'b0;
         done_o          = 1'b0;
         wrap_o          = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state       <= ST_IDLE;
         r_cfg         <= '0;
         r_shadow      <= '0;
         r_repeat_left <= '0;
         r_wrap        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wrap  <= w_reload;
         if (r_state == ST_IDLE && cfg_we_i) begin
            r_cfg <= '{limit: cfg_limit_i, periodic: cfg_periodic_i, repeat_cnt: cfg_repeat_i};
         end
         if (w_load) begin
            r_shadow      <= r_cfg;
            r_repeat_left <= r_cfg.repeat_cnt;
         end else if (w_reload && r_shadow.repeat_cnt != '0) begin
            r_repeat_left <= r_repeat_left - 1'b1;
         end
      end
   end

endmodule
